mem_arbiter: RTL and testbench

Arbitrates between the hart's instruction-fetch port and its data port for one shared single-ported synchronous memory, so a hart can run from a unified 1-cycle-latency RAM instead of separate imem/dmem banks. Each requester gets a request/grant handshake and a registered read-response strobe. Data accesses win by default; a starvation counter guarantees forward progress for fetch.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_prio.sv | 52 +++++
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam logic [3:0] MASK_WORD = 4'b1111;

  // A limit of 0 still needs a 1-bit counter so the declaration stays legal.
  function automatic int unsigned starve_cnt_w(input int unsigned limit);
    return (limit == 0) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Grant decision between fetch and data requesters, with a saturating
// starvation counter that forces a fetch grant after STARVE_LIMIT data grants.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_if_req,
  input  logic i_d_req,
  output logic o_if_gnt,
  output logic o_d_gnt
);

  localparam int unsigned CNT_W = starve_cnt_w(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             starved;

  always_comb begin
    starved  = (STARVE_LIMIT != 0) && (starve_q == LIMIT);
    o_if_gnt = 1'b0;
    o_d_gnt  = 1'b0;
    if (i_rst_n) begin
      if (i_d_req && !(i_if_req && starved)) begin
        o_d_gnt = 1'b1;
      end else if (i_if_req) begin
        o_if_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (o_if_gnt || !i_if_req) begin
      starve_d = '0;
    end else if (o_d_gnt && (starve_q != LIMIT)) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one 1-cycle-latency single-ported memory between fetch and data ports.
// Optional stall counters are enabled with the MEM_ARB_PERF_EN macro.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [31:0]       o_if_rdata,
  input  logic              i_d_req,
  input  logic              i_d_wen,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [31:0]       i_d_wdata,
  input  logic [3:0]        i_d_mask,
  output logic              o_d_gnt,
  output logic              o_d_rvalid,
  output logic [31:0]       o_d_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_ren,
  output logic              o_mem_wen,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_mask,
`ifdef MEM_ARB_PERF_EN
  output logic [31:0]       o_perf_if_stall,
  output logic [31:0]       o_perf_d_stall,
`endif
  input  logic [31:0]       i_mem_rdata
);

  logic   if_gnt, d_gnt;
  owner_e owner_q, owner_d;

  mem_arb_prio #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_prio (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_if_req (i_if_req),
    .i_d_req  (i_d_req),
    .o_if_gnt (if_gnt),
    .o_d_gnt  (d_gnt)
  );

  assign o_if_gnt = if_gnt;
  assign o_d_gnt  = d_gnt;

  always_comb begin
    o_mem_addr  = '0;
    o_mem_ren   = 1'b0;
    o_mem_wen   = 1'b0;
    o_mem_wdata = '0;
    o_mem_mask  = '0;
    if (if_gnt) begin
      o_mem_addr = i_if_addr;
      o_mem_ren  = 1'b1;
      o_mem_mask = MASK_WORD;
    end else if (d_gnt) begin
      o_mem_addr  = i_d_addr;
      o_mem_ren   = !i_d_wen;
      o_mem_wen   = i_d_wen;
      o_mem_wdata = i_d_wdata;
      o_mem_mask  = i_d_mask;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (d_gnt && !i_d_wen) begin
      owner_d = OWN_D;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Gating with reset drops a response whose grant preceded a reset cycle.
  assign o_if_rvalid = i_rst_n && (owner_q == OWN_IF);
  assign o_d_rvalid  = i_rst_n && (owner_q == OWN_D);
  assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
  assign o_d_rdata   = o_d_rvalid  ? i_mem_rdata : '0;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_q, perf_if_d;
  logic [31:0] perf_d_q,  perf_d_d;

  always_comb begin
    perf_if_d = perf_if_q + 32'(i_if_req && !if_gnt);
    perf_d_d  = perf_d_q  + 32'(i_d_req  && !d_gnt);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      perf_if_q <= '0;
      perf_d_q  <= '0;
    end else begin
      perf_if_q <= perf_if_d;
      perf_d_q  <= perf_d_d;
    end
  end

  assign o_perf_if_stall = perf_if_q;
  assign o_perf_d_stall  = perf_d_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a read-response scoreboard and a
// behavioural 1-cycle memory.
module tb_mem_arbiter;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        d_req = 1'b0, d_wen = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [3:0]  d_mask = '0;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
  logic [31:0] if_rdata, d_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ren, mem_wen;
  logic [3:0]  mem_mask;
  logic [31:0] mem_rdata = '0;

  logic        z_if_req = 1'b0, z_d_req = 1'b0;
  logic        z_if_gnt, z_if_rvalid, z_d_gnt, z_d_rvalid;
  logic [31:0] z_if_rdata, z_d_rdata, z_mem_addr, z_mem_wdata;
  logic        z_mem_ren, z_mem_wen;
  logic [3:0]  z_mem_mask;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if, perf_d, z_perf_if, z_perf_d;
`endif

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .STARVE_LIMIT(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt),
    .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
    .i_d_req(d_req), .i_d_wen(d_wen), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .i_d_mask(d_mask), .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
    .o_mem_addr(mem_addr), .o_mem_ren(mem_ren), .o_mem_wen(mem_wen),
    .o_mem_wdata(mem_wdata), .o_mem_mask(mem_mask),
`ifdef MEM_ARB_PERF_EN
    .o_perf_if_stall(perf_if), .o_perf_d_stall(perf_d),
`endif
    .i_mem_rdata(mem_rdata)
  );

  mem_arbiter #(.ADDR_W(32), .STARVE_LIMIT(0)) dut_strict (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(z_if_req), .i_if_addr(32'h100), .o_if_gnt(z_if_gnt),
    .o_if_rvalid(z_if_rvalid), .o_if_rdata(z_if_rdata),
    .i_d_req(z_d_req), .i_d_wen(1'b0), .i_d_addr(32'h200), .i_d_wdata(32'h0),
    .i_d_mask(4'hF), .o_d_gnt(z_d_gnt), .o_d_rvalid(z_d_rvalid), .o_d_rdata(z_d_rdata),
    .o_mem_addr(z_mem_addr), .o_mem_ren(z_mem_ren), .o_mem_wen(z_mem_wen),
    .o_mem_wdata(z_mem_wdata), .o_mem_mask(z_mem_mask),
`ifdef MEM_ARB_PERF_EN
    .o_perf_if_stall(z_perf_if), .o_perf_d_stall(z_perf_d),
`endif
    .i_mem_rdata(32'h0)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hAAAA_0001;
    if (i == 5) return 32'hAAAA_0002;
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // Behavioural memory; non-read cycles return garbage so rdata gating shows.
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (mem_wen) begin
      for (int b = 0; b < 4; b++)
        if (mem_mask[b]) mem[mem_addr[7:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
    mem_rdata <= mem_ren ? mem[mem_addr[7:2]] : 32'hDEAD_BEEF;
  end

  logic [31:0] ref_mem [64];

  typedef struct {
    int unsigned due;
    logic [31:0] data;
  } rsp_t;
  rsp_t if_q[$];
  rsp_t d_q[$];

  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response monitor: each scoreboard entry is due exactly one cycle after its grant.
  always @(negedge clk) begin
    logic ev;
    rsp_t e;
    ev = (if_q.size() > 0) && (if_q[0].due == cyc);
    chk("if_rvalid", 32'(if_rvalid), 32'(ev));
    if (ev) begin
      e = if_q.pop_front();
      chk("if_rdata", if_rdata, e.data);
    end else chk("if_rdata_idle", if_rdata, 32'h0);
    while (if_q.size() > 0 && if_q[0].due < cyc) e = if_q.pop_front();

    ev = (d_q.size() > 0) && (d_q[0].due == cyc);
    chk("d_rvalid", 32'(d_rvalid), 32'(ev));
    if (ev) begin
      e = d_q.pop_front();
      chk("d_rdata", d_rdata, e.data);
    end else chk("d_rdata_idle", d_rdata, 32'h0);
    while (d_q.size() > 0 && d_q[0].due < cyc) e = d_q.pop_front();
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic push_if(input logic [31:0] a);
    if_q.push_back('{due: cyc + 1, data: ref_mem[a[7:2]]});
  endtask

  task automatic push_d(input logic [31:0] a);
    d_q.push_back('{due: cyc + 1, data: ref_mem[a[7:2]]});
  endtask

  task automatic rd_if(input logic [31:0] a);
    next();
    d_req = 1'b0; if_req = 1'b1; if_addr = a;
    smp();
    chk("if_only_gnt", 32'(if_gnt), 32'h1);
    chk("if_only_dgnt", 32'(d_gnt), 32'h0);
    chk("if_mem_addr", mem_addr, a);
    chk("if_mem_ren", 32'({mem_ren, mem_wen}), 32'b10);
    chk("if_mem_mask", 32'(mem_mask), 32'hF);
    chk("if_mem_wdata", mem_wdata, 32'h0);
    push_if(a);
  endtask

  task automatic rd_d(input logic [31:0] a, input bit expect_rsp);
    next();
    if_req = 1'b0; d_req = 1'b1; d_wen = 1'b0; d_addr = a; d_mask = 4'hF;
    smp();
    chk("d_rd_gnt", 32'(d_gnt), 32'h1);
    chk("d_rd_mem_addr", mem_addr, a);
    chk("d_rd_mem_ren", 32'({mem_ren, mem_wen}), 32'b10);
    if (expect_rsp) push_d(a);
  endtask

  initial begin
    logic [31:0] ea;
    int ik, dk;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

    // Reset held with both requesters asserting.
    if_req = 1'b1; d_req = 1'b1; z_if_req = 1'b1; z_d_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk("rst_if_gnt", 32'(if_gnt), 32'h0);
      chk("rst_d_gnt", 32'(d_gnt), 32'h0);
      chk("rst_mem_en", 32'({mem_ren, mem_wen}), 32'h0);
      next();
    end
    rst_n = 1'b1; if_req = 1'b0; d_req = 1'b0; z_if_req = 1'b0; z_d_req = 1'b0;
    smp();
    chk("idle_mem_en", 32'({mem_ren, mem_wen}), 32'h0);
    chk("idle_mem_addr", mem_addr, 32'h0);
    chk("idle_mem_mask", 32'(mem_mask), 32'h0);

    // Contention: expect D,D,D,D,IF repeating.
    ik = 0; dk = 0;
    for (int k = 0; k < 10; k++) begin
      next();
      if_req = 1'b1; if_addr = 32'h40 + 32'(4 * ik);
      d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h80 + 32'(4 * dk); d_mask = 4'hF;
      smp();
      if ((k % 5) == 4) begin
        chk("starve_if_gnt", 32'(if_gnt), 32'h1);
        chk("starve_d_gnt", 32'(d_gnt), 32'h0);
        chk("starve_mem_addr", mem_addr, if_addr);
        push_if(if_addr);
        ik++;
      end else begin
        chk("starve_if_gnt", 32'(if_gnt), 32'h0);
        chk("starve_d_gnt", 32'(d_gnt), 32'h1);
        chk("starve_mem_addr", mem_addr, d_addr);
        push_d(d_addr);
        dk++;
      end
`ifdef MEM_ARB_PERF_EN
      if (k == 5) chk("perf_if_after_block", perf_if, 32'd4);
`endif
    end
    next();
    if_req = 1'b0; d_req = 1'b0;
    smp();
`ifdef MEM_ARB_PERF_EN
    chk("perf_if_total", perf_if, 32'd8);
    chk("perf_d_total", perf_d, 32'd2);
`endif

    // Back-to-back fetches, then a write overlapping the second fetch response.
    rd_if(32'h10);
    rd_if(32'h14);
    next();
    if_req = 1'b0; d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h20;
    d_wdata = 32'h1234_5678; d_mask = 4'b0101;
    smp();
    chk("wr_d_gnt", 32'(d_gnt), 32'h1);
    chk("wr_mem_en", 32'({mem_ren, mem_wen}), 32'b01);
    chk("wr_mem_mask", 32'(mem_mask), 32'h5);
    chk("wr_mem_wdata", mem_wdata, 32'h1234_5678);
    chk("wr_mem_addr", mem_addr, 32'h20);
    ea = ref_mem[8];
    for (int b = 0; b < 4; b++) if (d_mask[b]) ea[b*8 +: 8] = d_wdata[b*8 +: 8];
    ref_mem[8] = ea;

    // Read-back of the merged word, alternating owners.
    rd_d(32'h20, 1'b1);
    rd_if(32'h24);
    rd_d(32'h18, 1'b1);
    rd_if(32'h28);

    // A read granted right before reset must never respond.
    rd_d(32'h1C, 1'b0);
    next();
    rst_n = 1'b0; if_req = 1'b1;
    smp();
    chk("midrst_d_rvalid", 32'(d_rvalid), 32'h0);
    chk("midrst_gnt", 32'({if_gnt, d_gnt}), 32'h0);
    chk("midrst_mem_en", 32'({mem_ren, mem_wen}), 32'h0);
    next();
    rst_n = 1'b1; if_req = 1'b0; d_req = 1'b0;
    smp();
    chk("postrst_rvalid", 32'({if_rvalid, d_rvalid}), 32'h0);

    // Strict data priority: fetch never wins.
    for (int k = 0; k < 20; k++) begin
      next();
      z_if_req = 1'b1; z_d_req = 1'b1;
      smp();
      chk("strict_if_gnt", 32'(z_if_gnt), 32'h0);
      chk("strict_d_gnt", 32'(z_d_gnt), 32'h1);
    end
    next();
    z_if_req = 1'b0; z_d_req = 1'b0;
    next();
    smp();
    chk("if_q_drained", 32'(if_q.size()), 32'h0);
    chk("d_q_drained", 32'(d_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
